// File: rtl/auxpll_lf_if.sv
// Sample and tuning bundle between the aux PLL BBPD stage, this loop filter and the DCO.
// No handshake: pd is sampled on every ck250m edge and en decides whether the sample is used.
interface auxpll_lf_if #(
  parameter int FCW_W = 10
);
  logic             en;
  logic             pd;
  logic [FCW_W-1:0] dco_tune;
  logic             lock;
  logic [1:0]       state;

  modport master (output en, output pd, input dco_tune, input lock, input state);
  modport slave  (input en, input pd, output dco_tune, output lock, output state);
endinterface

// File: rtl/auxpll_lf.sv
// Bang-bang PI loop filter for the aux PLL: integrates BBPD early/late samples into a DCO
// tune word, shifting gears IDLE -> ACQ -> TRK, with toggle-density lock and run-length unlock.
module auxpll_lf #(
  parameter int FCW_W      = 10,
  parameter int FRAC_W     = 6,
  parameter int INIT       = 512,
  parameter int KP_ACQ     = 8,
  parameter int KI_ACQ     = 16,
  parameter int KP_TRK     = 2,
  parameter int KI_TRK     = 2,
  parameter int SETTLE     = 16,
  parameter int WIN        = 32,
  parameter int LOCK_TH    = 12,
  parameter int UNLOCK_RUN = 16
) (
  input  logic         ck250m,
  input  logic         nrst,
  auxpll_lf_if.slave   bus
);
  localparam int AW = FCW_W + FRAC_W;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);

  localparam logic [AW-1:0]    ACC_INIT    = {FCW_W'(INIT), {FRAC_W{1'b0}}};
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [WW-1:0]    WIN_LAST    = WW'(WIN - 1);
  localparam logic [WW-1:0]    LOCK_TH_C   = WW'(LOCK_TH);
  localparam logic [RW-1:0]    UNLOCK_C    = RW'(UNLOCK_RUN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRK = 2'd2} state_t;

  state_t           st;
  logic [AW-1:0]    acc;
  logic [FCW_W-1:0] tune;
  logic             lock;
  logic [SW-1:0]    settle_cnt;
  logic [WW-1:0]    win_cnt;
  logic [WW-1:0]    tog_cnt;
  logic [RW-1:0]    run_cnt;
  logic             pd_prev;
  logic             pd_vld;

  logic [AW-1:0]    ki;
  logic [FCW_W-1:0] kp;
  logic [AW+1:0]    acc_sum;
  logic [AW-1:0]    acc_n;
  logic [FCW_W+1:0] tune_sum;
  logic [FCW_W-1:0] tune_n;
  logic             toggle;
  logic [WW-1:0]    tog_next;
  logic [RW-1:0]    run_next;

  // Sums are two extra bits wide: top bit flags underflow, next bit flags overflow.
  always_comb begin
    ki = (st == TRK) ? AW'(KI_TRK) : AW'(KI_ACQ);
    kp = (st == TRK) ? FCW_W'(KP_TRK) : FCW_W'(KP_ACQ);

    acc_sum = bus.pd ? ({2'b00, acc} + {2'b00, ki}) : ({2'b00, acc} - {2'b00, ki});
    if (acc_sum[AW+1])   acc_n = '0;
    else if (acc_sum[AW]) acc_n = '1;
    else                  acc_n = acc_sum[AW-1:0];

    tune_sum = bus.pd ? ({2'b00, acc_n[AW-1:FRAC_W]} + {2'b00, kp})
                      : ({2'b00, acc_n[AW-1:FRAC_W]} - {2'b00, kp});
    if (tune_sum[FCW_W+1])  tune_n = '0;
    else if (tune_sum[FCW_W]) tune_n = '1;
    else                      tune_n = tune_sum[FCW_W-1:0];

    toggle   = pd_vld && (bus.pd != pd_prev);
    tog_next = (toggle && (tog_cnt != '1)) ? tog_cnt + 1'b1 : tog_cnt;

    // run_cnt == 0 marks the first sample after entering TRK.
    if (run_cnt == '0)           run_next = RW'(1);
    else if (bus.pd == pd_prev)  run_next = (run_cnt != '1) ? run_cnt + 1'b1 : run_cnt;
    else                         run_next = RW'(1);
  end

  always_ff @(posedge ck250m) begin
    if (!nrst) begin
      st         <= IDLE;
      acc        <= ACC_INIT;
      tune       <= FCW_W'(INIT);
      lock       <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      tog_cnt    <= '0;
      run_cnt    <= '0;
      pd_prev    <= 1'b0;
      pd_vld     <= 1'b0;
    end else if (!bus.en) begin
      st         <= IDLE;
      lock       <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      tog_cnt    <= '0;
      run_cnt    <= '0;
      pd_vld     <= 1'b0;
    end else begin
      case (st)
        ACQ: begin
          acc     <= acc_n;
          tune    <= tune_n;
          pd_prev <= bus.pd;
          pd_vld  <= 1'b1;
          if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            tog_cnt <= '0;
            if (tog_next >= LOCK_TH_C) begin
              st      <= TRK;
              lock    <= 1'b1;
              run_cnt <= '0;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            tog_cnt <= tog_next;
          end
        end
        TRK: begin
          acc     <= acc_n;
          tune    <= tune_n;
          pd_prev <= bus.pd;
          pd_vld  <= 1'b1;
          if (run_next == UNLOCK_C) begin
            st      <= ACQ;
            lock    <= 1'b0;
            run_cnt <= '0;
            win_cnt <= '0;
            tog_cnt <= '0;
            pd_vld  <= 1'b0;
          end else begin
            run_cnt <= run_next;
          end
        end
        default: begin
          // IDLE, and the unused encoding which behaves as IDLE.
          st   <= IDLE;
          lock <= 1'b0;
          if (settle_cnt == SETTLE_LAST) begin
            st         <= ACQ;
            settle_cnt <= '0;
            win_cnt    <= '0;
            tog_cnt    <= '0;
            pd_vld     <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.dco_tune = tune;
  assign bus.lock     = lock;
  assign bus.state    = st;
endmodule
